// File: rtl/lsu_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the load/store data bus: TXDATA/STATUS/CTRL window, TX FIFO, serialiser.
// Optional parity frame when UART_TX_PARITY_EN is defined (adds a PARITY bit between DATA and STOP).
module lsu_uart_tx #(
  parameter int          CLK_DIV    = 868,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            par_q, par_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            tx_en_q, tx_en_d;
  logic            irq_en_q, irq_en_d;
  logic            parity_odd_q, parity_odd_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            hit;
  logic [1:0]      offset;
  logic            wr_hit;
  logic            push_req;
  logic            status_wr;
  logic            ctrl_wr;
  logic            empty;
  logic            full;
  logic            busy;
  logic            bit_end;
  logic            frame_slot;
  logic            pop;
  logic            push_ok;
  logic [7:0]      head;
  logic            parity_odd_rd;
  logic [31:0]     status_word;
  logic [31:0]     ctrl_word;

  assign hit       = cs && (addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = addr[3:2];
  assign wr_hit    = hit && wr && mask[0];
  assign push_req  = wr_hit && (offset == 2'd0);
  assign status_wr = wr_hit && (offset == 2'd1);
  assign ctrl_wr   = wr_hit && (offset == 2'd2);

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign busy    = (state_q != S_IDLE);
  assign bit_end = (baud_q == '0);
  assign head    = mem_q[rd_ptr_q];

  // The last cycle of STOP doubles as an IDLE cycle so consecutive frames abut.
  assign frame_slot = (state_q == S_IDLE) || ((state_q == S_STOP) && bit_end);
  assign pop        = frame_slot && tx_en_q && !empty;
  assign push_ok    = push_req && (!full || pop);

`ifdef UART_TX_PARITY_EN
  assign parity_odd_rd = parity_odd_q;
`else
  assign parity_odd_rd = 1'b0;
`endif

  // FIFO bookkeeping and register writes.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    tx_en_d      = tx_en_q;
    irq_en_d     = irq_en_q;
    parity_odd_d = parity_odd_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end else if (status_wr && data_wr[3]) begin
      overflow_d = 1'b0;
    end
    if (ctrl_wr) begin
      tx_en_d  = data_wr[0];
      irq_en_d = data_wr[2];
`ifdef UART_TX_PARITY_EN
      parity_odd_d = data_wr[1];
`endif
    end
  end

  // Serialiser next state; a pop overrides whatever the current state decided.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    par_d     = par_q;
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? BAUD_RELOAD : baud_q - 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (pop) begin
      state_d   = S_START;
      baud_d    = BAUD_RELOAD;
      bit_idx_d = 3'd0;
      shift_d   = head;
      tx_d      = 1'b0;
      par_d     = (^head) ^ parity_odd_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      tx_q         <= 1'b1;
      par_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      tx_en_q      <= 1'b1;
      irq_en_q     <= 1'b0;
      parity_odd_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      par_q        <= par_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      tx_en_q      <= tx_en_d;
      irq_en_q     <= irq_en_d;
      parity_odd_q <= parity_odd_d;
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_wr[7:0];
  end

  assign status_word = {20'h0, 4'(count_q), 4'h0, overflow_q, empty, full, busy};
  assign ctrl_word   = {29'h0, irq_en_q, parity_odd_rd, tx_en_q};

  always_comb begin
    data_rd = 32'h0;
    if (hit && !wr) begin
      case (offset)
        2'd1:    data_rd = status_word;
        2'd2:    data_rd = ctrl_word;
        default: data_rd = 32'h0;
      endcase
    end
  end

  assign tx  = tx_q;
  assign irq = irq_en_q && empty && (state_q == S_IDLE);

  logic unused_ok;
`ifdef UART_TX_PARITY_EN
  assign unused_ok = ^{addr[1:0], data_wr[31:8], mask[3:1]};
`else
  assign unused_ok = ^{addr[1:0], data_wr[31:8], mask[3:1], par_q, parity_odd_q};
`endif

endmodule

// File: tb/tb_lsu_uart_tx.sv
// Bench for lsu_uart_tx: bus driver tasks, serial-line monitor with an expected-byte scoreboard, final report.
module tb_lsu_uart_tx;

  localparam int          CLK_DIV = 4;
  localparam int          DEPTH   = 8;
  localparam logic [31:0] BASE    = 32'h8000_0000;
`ifdef UART_TX_PARITY_EN
  localparam int          NB      = 11;
`else
  localparam int          NB      = 10;
`endif

  logic        clk;
  logic        rst;
  logic        cs;
  logic        wr;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        tx;
  logic        irq;

  lsu_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .wr      (wr),
    .mask    (mask),
    .addr    (addr),
    .data_wr (data_wr),
    .data_rd (data_rd),
    .tx      (tx),
    .irq     (irq)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] exp_q[$];   // {expected parity bit, data byte}
  int         start_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Driver tasks: one bus beat per cycle, inputs changed on the falling edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; data_wr = d; mask = m;
    @(posedge clk);
    #1;
    cs = 1'b0; wr = 1'b0; mask = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b0; addr = a;
    #1;
    d = data_rd;
    cs = 1'b0;
  endtask

  task automatic store_byte(input logic [7:0] b, input logic par_odd);
    bus_write(BASE, {24'h0, b}, 4'hF);
    exp_q.push_back({(^b) ^ par_odd, b});
  endtask

  task automatic wait_busy(output bit ok);
    logic [31:0] s;
    int w;
    w = 0;
    bus_read(BASE + 32'h4, s);
    while (!s[0] && w < 200) begin
      w++;
      bus_read(BASE + 32'h4, s);
    end
    ok = s[0];
    if (!ok) check("busy_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic measure_busy(output int n);
    logic [31:0] s;
    bit ok;
    n = 0;
    wait_busy(ok);
    s = 32'h1;
    while (ok && s[0] && n < 2000) begin
      n++;
      bus_read(BASE + 32'h4, s);
    end
  endtask

  // Serial monitor: frames start on the first low cycle, bits sampled mid-period
  initial begin : monitor
    logic [NB-1:0] obs;
    logic [NB-1:0] expw;
    logic [8:0]    e;
    logic          bit_ref;
    int            glitches;
    int            t0;
    bit            aborted;
    bit_ref = 1'b1;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        t0 = cyc; obs = '0; glitches = 0; aborted = 1'b0;
        for (int c = 0; c < NB * CLK_DIV; c++) begin
          if (c > 0) @(negedge clk);
          if (rst !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (c % CLK_DIV == 0) bit_ref = tx;
          else if (tx !== bit_ref) glitches++;
          if (c % CLK_DIV == CLK_DIV / 2) obs[c / CLK_DIV] = tx;
        end
        if (!aborted) begin
          start_q.push_back(t0);
          check("frame_stable", glitches, 0);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {{(32-NB){1'b0}}, obs}, 32'h0);
          end else begin
            e = exp_q.pop_front();
`ifdef UART_TX_PARITY_EN
            expw = {1'b1, e[8], e[7:0], 1'b0};
`else
            expw = {1'b1, e[7:0], 1'b0};
`endif
            check("frame", {{(32-NB){1'b0}}, obs}, {{(32-NB){1'b0}}, expw});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] rd;
    int          n;
    int          low;
    bit          ok;
    logic [7:0]  b;
    rst = 1'b0; cs = 1'b0; wr = 1'b0; mask = 4'h0; addr = 32'h0; data_wr = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Reset state
    bus_read(BASE + 32'h4, rd); check("rst_status", rd, 32'h4);
    bus_read(BASE + 32'h8, rd); check("rst_ctrl", rd, 32'h1);
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h0);

    // Single frame 0xA5
    store_byte(8'hA5, 1'b0);
    measure_busy(n);
    check("busy_cycles_a5", n, 10 * CLK_DIV * NB / 10);
    bus_read(BASE + 32'h4, rd); check("status_after_a5", rd, 32'h4);

    // Fill with tx disabled, overflow on the ninth store
    bus_write(BASE + 32'h8, 32'h0, 4'h1);
    for (int i = 0; i < 9; i++) begin
      b = 8'(i * 37 + 3);
      bus_write(BASE, {24'h0, b}, 4'hF);
      if (i < DEPTH) exp_q.push_back({^b, b});
    end
    bus_read(BASE + 32'h4, rd); check("status_full_ovf", rd, 32'h0000_080A);
    bus_write(BASE + 32'h4, 32'h8, 4'h1);
    bus_read(BASE + 32'h4, rd); check("status_ovf_clr", rd, 32'h0000_0802);
    start_q.delete();
    bus_write(BASE + 32'h8, 32'h1, 4'h1);
    measure_busy(n);
    check("burst_busy_cycles", n, DEPTH * NB * CLK_DIV);
    repeat (2) @(negedge clk);
    check("burst_frames", start_q.size(), DEPTH);
    for (int i = 1; i < start_q.size(); i++) check("burst_gap", start_q[i] - start_q[i-1], NB * CLK_DIV);
    bus_read(BASE + 32'h4, rd); check("status_after_burst", rd, 32'h4);

    // Ignored accesses
    bus_write(BASE, 32'h0000_0077, 4'b0010);
    bus_read(BASE + 32'h4, rd); check("mask_no_push", rd, 32'h4);
    bus_write(BASE + 32'h10, 32'h0000_0055, 4'hF);
    bus_read(BASE + 32'h4, rd); check("outside_no_push", rd, 32'h4);
    bus_read(BASE + 32'h10, rd); check("outside_read", rd, 32'h0);
    bus_read(BASE + 32'h0, rd); check("txdata_read", rd, 32'h0);
    bus_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
    bus_read(BASE + 32'hC, rd); check("reserved_read", rd, 32'h0);
    bus_read(BASE + 32'h8, rd); check("ctrl_unchanged", rd, 32'h1);

    // Reset mid-frame on a data-low cycle
    bus_write(BASE, 32'h0, 4'hF);
    wait_busy(ok);
    repeat (15) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_tx", {31'h0, tx}, 32'h1);
    check("midreset_irq", {31'h0, irq}, 32'h0);
    bus_read(BASE + 32'h4, rd); check("midreset_status", rd, 32'h4);
    @(negedge clk); #2 rst = 1'b1;
    low = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    check("no_resume", low, 0);
    bus_read(BASE + 32'h4, rd); check("post_reset_status", rd, 32'h4);
    bus_read(BASE + 32'h8, rd); check("post_reset_ctrl", rd, 32'h1);

    // irq: low for the queued cycle plus one whole frame after the push
    bus_write(BASE + 32'h8, 32'h5, 4'h1);
    check("irq_idle_empty", {31'h0, irq}, 32'h1);
    store_byte(8'h3C, 1'b0);
    low = 0;
    @(negedge clk);
    while (!irq && low < 500) begin
      low++;
      @(negedge clk);
    end
    check("irq_low_cycles", low, 1 + NB * CLK_DIV);
    check("irq_back_high", {31'h0, irq}, 32'h1);

    // Parity control bit
    bus_write(BASE + 32'h8, 32'h3, 4'h1);
    bus_read(BASE + 32'h8, rd);
`ifdef UART_TX_PARITY_EN
    check("ctrl_parity_rd", rd, 32'h3);
    store_byte(8'h01, 1'b1);
`else
    check("ctrl_parity_rd", rd, 32'h1);
    store_byte(8'h01, 1'b0);
`endif
    measure_busy(n);
    check("parity_frame_cycles", n, NB * CLK_DIV);

    // Random back-to-back bytes
    bus_write(BASE + 32'h8, 32'h0, 4'h1);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      store_byte(b, 1'b0);
    end
    bus_write(BASE + 32'h8, 32'h1, 4'h1);
    measure_busy(n);
    check("random_busy_cycles", n, 4 * NB * CLK_DIV);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
